ir_tx_nec: RTL

- NEC-protocol infrared transmitter; the transmit-side counterpart of the IR receiver component in the kernel Qsys system.
- Accepts an 8-bit address and an 8-bit command through a valid/ready handshake.
- Serialises them as a standard NEC frame: leader, addr, ~addr, cmd, ~cmd (LSB first), then a stop mark.
- Drives an IR LED pin with carrier-modulated marks; sits beside the IR receiver and LCD controller as a conduit-exported peripheral.

---
 rtl/ir_tx_nec.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ir_tx_nec.sv
// NEC infrared transmitter: leader, addr, ~addr, cmd, ~cmd (LSB first), stop mark, then gap.
// Define IR_TX_REPEAT_EN to send NEC repeat codes while tx_valid stays high after a frame.
module ir_tx_nec #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658,
    parameter bit MODULATE     = 1'b1,
    parameter int FRAME_UNITS  = 192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    output logic       tx_ready,
    output logic       busy,
    output logic       ir_out
);
    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CAR_MAX    = CW'(CARRIER_HALF - 1);
    localparam logic [7:0]    FRAME_MAX  = 8'(FRAME_UNITS);
    localparam logic [7:0]    FRAME_LAST = 8'(FRAME_UNITS - 1);

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
`ifdef IR_TX_REPEAT_EN
        ,
        REP_MARK,
        REP_SPACE,
        REP_STOP
`endif
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    unit_cnt;
    logic [7:0]    frame_units;
    logic [CW-1:0] car_cnt;
    logic          phase;
    logic [31:0]   shreg;
    logic [4:0]    bit_idx;

    logic       tick;
    logic       car_wrap;
    logic       gap_done;
    logic       in_mark;
    logic       unit_done;
    logic [3:0] unit_last;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick      = (presc == PRESC_MAX);
        car_wrap  = (car_cnt == CAR_MAX);
        gap_done  = (frame_units == FRAME_MAX) || (tick && (frame_units == FRAME_LAST));
        unit_last = 4'd0;
        in_mark   = 1'b0;
        case (state)
            LEAD_MARK: begin
                unit_last = 4'd15;
                in_mark   = 1'b1;
            end
            LEAD_SPACE: unit_last = 4'd7;
            BIT_MARK:   in_mark = 1'b1;
            BIT_SPACE:  unit_last = shreg[0] ? 4'd2 : 4'd0;
            STOP_MARK:  in_mark = 1'b1;
`ifdef IR_TX_REPEAT_EN
            REP_MARK: begin
                unit_last = 4'd15;
                in_mark   = 1'b1;
            end
            REP_SPACE: unit_last = 4'd3;
            REP_STOP:  in_mark = 1'b1;
`endif
            default: ;
        endcase
        unit_done = tick && (unit_cnt == unit_last);
    end

    // NOTE: non-blocking assignments throughout; a later assignment in the same cycle
    // (state transition) deliberately overrides the generic counter/carrier update above it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            unit_cnt    <= '0;
            frame_units <= '0;
            car_cnt     <= '0;
            phase       <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ir_out      <= 1'b0;
        end else begin
            if (state != IDLE) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    unit_cnt <= unit_done ? 4'd0 : unit_cnt + 4'd1;
                    if (frame_units != FRAME_MAX) frame_units <= frame_units + 8'd1;
                end
            end

            if (in_mark) begin
                if (car_wrap) begin
                    car_cnt <= '0;
                    phase   <= ~phase;
                    ir_out  <= MODULATE ? ~phase : 1'b1;
                end else begin
                    car_cnt <= car_cnt + CW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg       <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                        bit_idx     <= '0;
                        presc       <= '0;
                        unit_cnt    <= '0;
                        frame_units <= '0;
                        car_cnt     <= '0;
                        phase       <= 1'b1;
                        ir_out      <= 1'b1;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LEAD_MARK;
                    end
                end
                LEAD_MARK: begin
                    if (unit_done) begin
                        state  <= LEAD_SPACE;
                        ir_out <= 1'b0;
                    end
                end
                LEAD_SPACE: begin
                    if (unit_done) begin
                        state   <= BIT_MARK;
                        car_cnt <= '0;
                        phase   <= 1'b1;
                        ir_out  <= 1'b1;
                    end
                end
                BIT_MARK: begin
                    if (unit_done) begin
                        state  <= BIT_SPACE;
                        ir_out <= 1'b0;
                    end
                end
                BIT_SPACE: begin
                    if (unit_done) begin
                        shreg   <= {1'b0, shreg[31:1]};
                        bit_idx <= bit_idx + 5'd1;
                        state   <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                        car_cnt <= '0;
                        phase   <= 1'b1;
                        ir_out  <= 1'b1;
                    end
                end
                STOP_MARK: begin
                    if (unit_done) begin
                        state  <= GAP;
                        ir_out <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_done) begin
`ifdef IR_TX_REPEAT_EN
                        if (tx_valid) begin
                            presc       <= '0;
                            unit_cnt    <= '0;
                            frame_units <= '0;
                            car_cnt     <= '0;
                            phase       <= 1'b1;
                            ir_out      <= 1'b1;
                            state       <= REP_MARK;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                        end
`else
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
`endif
                    end
                end
`ifdef IR_TX_REPEAT_EN
                REP_MARK: begin
                    if (unit_done) begin
                        state  <= REP_SPACE;
                        ir_out <= 1'b0;
                    end
                end
                REP_SPACE: begin
                    if (unit_done) begin
                        state   <= REP_STOP;
                        car_cnt <= '0;
                        phase   <= 1'b1;
                        ir_out  <= 1'b1;
                    end
                end
                REP_STOP: begin
                    if (unit_done) begin
                        state  <= GAP;
                        ir_out <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    ir_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule
